// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the FSM state encoding, the NOP word and the reset PC default.
package instr_fetch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StIssue,
        StHalted
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC select for the fetch stage.
// Priority is jalr > jal > branch > sequential, and the chosen target is checked for alignment.
module instr_fetch_next_pc (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1_data,
    input  logic        i_branch_taken,
    input  logic        i_jal,
    input  logic        i_jalr,
    output logic [31:0] o_next_pc,
    output logic        o_misaligned
);

    logic [31:0] w_jalr_sum;

    assign w_jalr_sum = i_rs1_data + i_imm;

    always_comb begin
        o_next_pc = i_pc + 32'd4;
        if (i_jalr) begin
            o_next_pc = w_jalr_sum & ~32'h1;
        end else if (i_jal || i_branch_taken) begin
            o_next_pc = i_pc + i_imm;
        end
    end

    assign o_misaligned = |o_next_pc[1:0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction BRAM and
// presents one instruction per issue slot, applying its redirect before the next fetch.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int unsigned ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    output logic              o_imem_en,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_rdata,
    input  logic              i_stall,
    input  logic              i_branch_taken,
    input  logic              i_jal,
    input  logic              i_jalr,
    input  logic [31:0]       i_imm,
    input  logic [31:0]       i_rs1_data,
    input  logic              i_halt,
    output logic [31:0]       o_instruction,
    output logic [31:0]       o_pc,
    output logic [31:0]       o_pc_plus4,
    output logic              o_inst_valid,
    output logic              o_misaligned
);

    fetch_state_e r_state;
    fetch_state_e w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_instruction;
    logic         r_misaligned;

    logic [31:0]  w_next_pc;
    logic         w_target_misaligned;
    logic         w_capture;
    logic         w_pc_load;
    logic         w_set_misaligned;

    instr_fetch_next_pc u_next_pc (
        .i_pc           (r_pc),
        .i_imm          (i_imm),
        .i_rs1_data     (i_rs1_data),
        .i_branch_taken (i_branch_taken),
        .i_jal          (i_jal),
        .i_jalr         (i_jalr),
        .o_next_pc      (w_next_pc),
        .o_misaligned   (w_target_misaligned)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= StIdle;
            r_pc          <= PC_RESET;
            r_instruction <= NOP_INSTR;
            r_misaligned  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_instruction <= i_imem_rdata;
            end
            if (w_pc_load) begin
                r_pc <= w_next_pc;
            end
            if (w_set_misaligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

    // Redirect inputs only matter in ISSUE with no stall; halt beats any redirect.
    always_comb begin
        w_state_next     = r_state;
        w_capture        = 1'b0;
        w_pc_load        = 1'b0;
        w_set_misaligned = 1'b0;
        o_imem_en        = 1'b0;
        o_inst_valid     = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_state_next = StFetch;
            end
            StFetch: begin
                o_imem_en    = 1'b1;
                w_state_next = StWait;
            end
            StWait: begin
                w_capture    = 1'b1;
                w_state_next = StIssue;
            end
            StIssue: begin
                o_inst_valid = 1'b1;
                if (!i_stall) begin
                    if (i_halt) begin
                        w_state_next = StHalted;
                    end else if (w_target_misaligned) begin
                        w_set_misaligned = 1'b1;
                        w_state_next     = StHalted;
                    end else begin
                        w_pc_load    = 1'b1;
                        w_state_next = StFetch;
                    end
                end
            end
            StHalted: begin
                w_state_next = StHalted;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign o_imem_addr   = r_pc[ADDR_W+1:2];
    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;
    assign o_pc_plus4    = r_pc + 32'd4;
    assign o_misaligned  = r_misaligned;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table of issue-slot redirects plus
// hand-written stall, halt, reset-in-WAIT and misaligned-target sequences.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic        jal;
    logic        jalr;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic        halt;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        br;
        logic        jl;
        logic        jr;
        logic [31:0] imm_v;
        logic [31:0] rs1_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs [9];

    instr_fetch #(
        .PC_RESET (32'h0000_0000),
        .ADDR_W   (14)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .o_imem_en      (imem_en),
        .o_imem_addr    (imem_addr),
        .i_imem_rdata   (imem_rdata),
        .i_stall        (stall),
        .i_branch_taken (branch_taken),
        .i_jal          (jal),
        .i_jalr         (jalr),
        .i_imm          (imm),
        .i_rs1_data     (rs1_data),
        .i_halt         (halt),
        .o_instruction  (instruction),
        .o_pc           (pc),
        .o_pc_plus4     (pc_plus4),
        .o_inst_valid   (inst_valid),
        .o_misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word a holds addi x(a+1), x0, a+1 (words 0..2 = 0x00100093, 0x00200113, 0x00300193).
    function automatic logic [31:0] mem_word(input logic [13:0] a);
        logic [31:0] n;
        n = 32'(a) + 32'd1;
        return (n << 20) | (n << 7) | 32'h0000_0013;
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 8) begin
            step();
            n++;
        end
        total++;
        if (!inst_valid) begin
            bad++;
            $display("FAIL %s: inst_valid got 0 want 1 within 8 cycles", name);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; branch_taken = 0; jal = 0; jalr = 0; halt = 0;
        imm = '0; rs1_data = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0008, 32'h0000_000C};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_000C, 32'h0000_0010};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0000_0000, 32'h0000_0010, 32'h0000_0008};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0101, 32'h0000_0008, 32'h0000_0120};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 32'h0000_0120, 32'h0000_0220};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0014, 32'hFFFF_FFF0, 32'h0000_0220, 32'h0000_0004};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0000_0000, 32'h0000_0004, 32'h0000_0010};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0000_0000, 32'h0000_0010, 32'hFFFF_0010};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0001_0000, 32'h0000_0000, 32'hFFFF_0010, 32'h0000_0010};

        clear_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc", pc, 32'h0);
        chk("reset_instr", instruction, 32'h0000_0013);
        chk("reset_valid", 32'(inst_valid), 32'd0);
        chk("reset_imem_en", 32'(imem_en), 32'd0);
        chk("reset_misaligned", 32'(misaligned), 32'd0);

        // Deassert: issues appear in cycles 4, 7, 10 counting the deassert cycle as 1.
        rst = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            logic [31:0] epc;
            step();
            chk("startup_valid", 32'(inst_valid), (k % 3 == 0) ? 32'd1 : 32'd0);
            if (k % 3 == 0) begin
                epc = 32'((k / 3 - 1) * 4);
                chk("startup_pc", pc, epc);
                chk("startup_instr", instruction, mem_word(epc[15:2]));
            end
        end

        for (int i = 0; i < 9; i++) begin
            logic [31:0] nx;
            wait_valid("vec_wait");
            chk("vec_pc", pc, vecs[i].exp_pc);
            chk("vec_instr", instruction, mem_word(vecs[i].exp_pc[15:2]));
            chk("vec_pc_plus4", pc_plus4, vecs[i].exp_pc + 32'd4);
            branch_taken = vecs[i].br;
            jal          = vecs[i].jl;
            jalr         = vecs[i].jr;
            imm          = vecs[i].imm_v;
            rs1_data     = vecs[i].rs1_v;
            step();
            clear_inputs();
            nx = vecs[i].exp_next;
            chk("vec_imem_en", 32'(imem_en), 32'd1);
            chk("vec_imem_addr", 32'(imem_addr), 32'(nx[15:2]));
            chk("vec_next_pc", pc, nx);
        end

        // Stall with halt and a redirect pending: everything held, nothing taken.
        wait_valid("stall_wait");
        chk("stall_pc0", pc, 32'h10);
        stall = 1; halt = 1; jal = 1; imm = 32'h40;
        for (int s = 0; s < 5; s++) begin
            step();
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", pc, 32'h10);
            chk("stall_instr", instruction, mem_word(14'd4));
            chk("stall_imem_en", 32'(imem_en), 32'd0);
        end
        clear_inputs();
        step();
        chk("unstall_valid", 32'(inst_valid), 32'd0);
        chk("unstall_imem_en", 32'(imem_en), 32'd1);
        chk("unstall_addr", 32'(imem_addr), 32'd5);

        // Halt together with a redirect: halt wins and pc stays.
        wait_valid("halt_wait");
        chk("halt_pc0", pc, 32'h14);
        halt = 1; jal = 1; imm = 32'h40;
        step();
        clear_inputs();
        for (int s = 0; s < 4; s++) begin
            chk("halted_valid", 32'(inst_valid), 32'd0);
            chk("halted_imem_en", 32'(imem_en), 32'd0);
            chk("halted_pc", pc, 32'h14);
            step();
        end
        chk("halted_misaligned", 32'(misaligned), 32'd0);

        // Restart, then reset in the middle of WAIT for pc=4.
        rst = 1'b0;
        step();
        rst = 1'b1;
        wait_valid("restart_wait");
        chk("restart_pc", pc, 32'h0);
        step();
        chk("refetch_pc", pc, 32'h4);
        step();
        rst = 1'b0;
        step();
        chk("wait_rst_pc", pc, 32'h0);
        chk("wait_rst_instr", instruction, 32'h0000_0013);
        chk("wait_rst_valid", 32'(inst_valid), 32'd0);
        chk("wait_rst_imem_en", 32'(imem_en), 32'd0);
        rst = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("rerun_valid", 32'(inst_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("rerun_pc", pc, 32'h0);
        chk("rerun_instr", instruction, mem_word(14'd0));

        // Misaligned jal target from pc=0.
        jal = 1; imm = 32'h6;
        step();
        clear_inputs();
        for (int s = 0; s < 3; s++) begin
            chk("misal_flag", 32'(misaligned), 32'd1);
            chk("misal_valid", 32'(inst_valid), 32'd0);
            chk("misal_imem_en", 32'(imem_en), 32'd0);
            chk("misal_pc", pc, 32'h0);
            branch_taken = 1; imm = 32'h4;
            step();
            clear_inputs();
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("misal_cleared", 32'(misaligned), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
